// File: rtl/hub75_capture_pkg.sv
// Shared constants and types for the HUB75 panel-side capture block.
// Line entries are packed as {rgb2, rgb1} with the B,G,R order of the panel.
package hub75_capture_pkg;

    localparam int DEF_COLUMNS   = 64;
    localparam int DEF_COL_WIDTH = 6;
    localparam int DEF_ROW_WIDTH = 4;
    localparam int ENTRY_WIDTH   = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } cap_state_e;

    function automatic logic [ENTRY_WIDTH-1:0] pack_entry(input logic [2:0] rgb2,
                                                          input logic [2:0] rgb1);
        return {rgb2, rgb1};
    endfunction

endpackage

// File: rtl/hub75_edge_sync.sv
// Synchronizes one asynchronous HUB75 control line and emits a one-cycle
// registered pulse on each rising edge seen at the end of the chain.
module hub75_edge_sync
    import hub75_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = din;
        prev_d    = sync_q[SYNC_STAGES-1];
        rise_d    = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/hub75_capture.sv
// Panel-side HUB75 receiver: rebuilds each latched line in a holding buffer
// and replays it as a valid/ready pixel stream, flagging overrun and bad lengths.
module hub75_capture
    import hub75_capture_pkg::*;
#(
    parameter int COLUMNS     = DEF_COLUMNS,
    parameter int COL_WIDTH   = DEF_COL_WIDTH,
    parameter int ROW_WIDTH   = DEF_ROW_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 cap_enable,
    input  logic                 clear_flags,
    input  logic                 hub_clk_pixel,
    input  logic                 hub_row_latch,
    input  logic [ROW_WIDTH-1:0] hub_row_addr,
    input  logic [2:0]           hub_rgb1,
    input  logic [2:0]           hub_rgb2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_WIDTH-1:0] out_row,
    output logic [COL_WIDTH-1:0] out_column,
    output logic [2:0]           out_rgb1,
    output logic [2:0]           out_rgb2,
    output logic                 out_last,
    output logic                 overrun,
    output logic                 length_error,
    output logic [7:0]           lines_captured
);

    localparam int CNT_WIDTH = $clog2(COLUMNS + 2);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(COLUMNS);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(COLUMNS + 1);
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(COLUMNS - 1);

    typedef logic [ENTRY_WIDTH-1:0]              entry_t;
    typedef logic [COLUMNS-1:0][ENTRY_WIDTH-1:0] line_t;

    logic pix_rise, lat_rise;

    entry_t [SYNC_STAGES-1:0]              rgb_sync_q, rgb_sync_d;
    logic   [SYNC_STAGES-1:0][ROW_WIDTH-1:0] row_sync_q, row_sync_d;
    entry_t                 rgb_algn_q, rgb_algn_d, rgb_evt_q, rgb_evt_d;
    logic [ROW_WIDTH-1:0]   row_algn_q, row_algn_d, row_evt_q, row_evt_d;
    logic                   pix_evt_q, pix_evt_d, lat_evt_q, lat_evt_d;

    line_t                  shift_q, shift_d, hold_q, hold_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d, line_len;
    cap_state_e             state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [ROW_WIDTH-1:0]   out_row_q, out_row_d;
    logic [COL_WIDTH-1:0]   out_column_q, out_column_d, col_next;
    logic [2:0]             out_rgb1_q, out_rgb1_d, out_rgb2_q, out_rgb2_d;
    logic                   out_last_q, out_last_d;
    logic                   overrun_q, overrun_d, length_error_q, length_error_d;
    logic [7:0]             lines_q, lines_d;

    hub75_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pix_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (hub_clk_pixel),
        .rise   (pix_rise)
    );

    hub75_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lat_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (hub_row_latch),
        .rise   (lat_rise)
    );

    // Data chains end in an align stage so they line up with the registered edge pulses.
    always_comb begin
        rgb_sync_d = rgb_sync_q;
        row_sync_d = row_sync_q;
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            rgb_sync_d[i] = rgb_sync_q[i-1];
            row_sync_d[i] = row_sync_q[i-1];
        end
        rgb_sync_d[0] = pack_entry(hub_rgb2, hub_rgb1);
        row_sync_d[0] = hub_row_addr;
        rgb_algn_d    = rgb_sync_q[SYNC_STAGES-1];
        row_algn_d    = row_sync_q[SYNC_STAGES-1];
        rgb_evt_d     = rgb_algn_q;
        row_evt_d     = row_algn_q;
        pix_evt_d     = pix_rise & cap_enable;
        lat_evt_d     = lat_rise & cap_enable;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rgb_sync_q <= '0;
            row_sync_q <= '0;
            rgb_algn_q <= '0;
            row_algn_q <= '0;
            rgb_evt_q  <= '0;
            row_evt_q  <= '0;
            pix_evt_q  <= 1'b0;
            lat_evt_q  <= 1'b0;
        end else begin
            rgb_sync_q <= rgb_sync_d;
            row_sync_q <= row_sync_d;
            rgb_algn_q <= rgb_algn_d;
            row_algn_q <= row_algn_d;
            rgb_evt_q  <= rgb_evt_d;
            row_evt_q  <= row_evt_d;
            pix_evt_q  <= pix_evt_d;
            lat_evt_q  <= lat_evt_d;
        end
    end

    // The shift is resolved before the latch so a coincident pixel joins the line.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (pix_evt_q) begin
            for (int i = COLUMNS - 1; i > 0; i--) begin
                shift_d[i] = shift_q[i-1];
            end
            shift_d[0] = rgb_evt_q;
            if (count_q != CNT_SAT) begin
                count_d = count_q + 1'b1;
            end
        end
        line_len = count_d;
        if (lat_evt_q) begin
            count_d = '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        out_valid_d    = out_valid_q;
        out_row_d      = out_row_q;
        out_column_d   = out_column_q;
        out_rgb1_d     = out_rgb1_q;
        out_rgb2_d     = out_rgb2_q;
        out_last_d     = out_last_q;
        lines_d        = lines_q;
        overrun_d      = overrun_q & ~clear_flags;
        length_error_d = length_error_q & ~clear_flags;
        col_next       = out_column_q + 1'b1;

        if (state_q == ST_DRAIN && out_ready) begin
            if (out_last_q) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_column_d              = col_next;
                {out_rgb2_d, out_rgb1_d}  = hold_q[col_next];
                out_last_d                = (col_next == COL_LAST);
            end
        end

        // A latch during a drain is dropped; the active stream is never disturbed.
        if (lat_evt_q) begin
            if (line_len != CNT_FULL) begin
                length_error_d = 1'b1;
            end
            if (state_q == ST_IDLE) begin
                state_d                  = ST_DRAIN;
                hold_d                   = shift_d;
                out_valid_d              = 1'b1;
                out_row_d                = row_evt_q;
                out_column_d             = '0;
                {out_rgb2_d, out_rgb1_d} = shift_d[0];
                out_last_d               = 1'b0;
                lines_d                  = lines_q + 8'd1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shift_q        <= '0;
            count_q        <= '0;
            hold_q         <= '0;
            state_q        <= ST_IDLE;
            out_valid_q    <= 1'b0;
            out_row_q      <= '0;
            out_column_q   <= '0;
            out_rgb1_q     <= '0;
            out_rgb2_q     <= '0;
            out_last_q     <= 1'b0;
            overrun_q      <= 1'b0;
            length_error_q <= 1'b0;
            lines_q        <= '0;
        end else begin
            shift_q        <= shift_d;
            count_q        <= count_d;
            hold_q         <= hold_d;
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_row_q      <= out_row_d;
            out_column_q   <= out_column_d;
            out_rgb1_q     <= out_rgb1_d;
            out_rgb2_q     <= out_rgb2_d;
            out_last_q     <= out_last_d;
            overrun_q      <= overrun_d;
            length_error_q <= length_error_d;
            lines_q        <= lines_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_row        = out_row_q;
    assign out_column     = out_column_q;
    assign out_rgb1       = out_rgb1_q;
    assign out_rgb2       = out_rgb2_q;
    assign out_last       = out_last_q;
    assign overrun        = overrun_q;
    assign length_error   = length_error_q;
    assign lines_captured = lines_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Self-checking bench for hub75_capture: drives HUB75 lines with random pixels
// and compares the replayed stream and flags against a line-level model.
module tb_hub75_capture;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       cap_enable = 1'b1;
    logic       clear_flags = 1'b0;
    logic       hub_clk_pixel = 1'b0;
    logic       hub_row_latch = 1'b0;
    logic [3:0] hub_row_addr = '0;
    logic [2:0] hub_rgb1 = '0;
    logic [2:0] hub_rgb2 = '0;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_row;
    logic [5:0] out_column;
    logic [2:0] out_rgb1;
    logic [2:0] out_rgb2;
    logic       out_last;
    logic       overrun;
    logic       length_error;
    logic [7:0] lines_captured;

    // Line model: newest pixel at index 0, expected stream beats in order.
    logic [5:0]  modelSr[$];
    logic [16:0] expQ[$];
    int          modelCount;
    int          expLines;
    logic        expOverrun;
    logic        expLenErr;

    int   checks = 0;
    int   failures = 0;
    int   beatsSeen = 0;
    logic holdReady = 1'b0;
    logic randomReady = 1'b0;

    hub75_capture dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .cap_enable     (cap_enable),
        .clear_flags    (clear_flags),
        .hub_clk_pixel  (hub_clk_pixel),
        .hub_row_latch  (hub_row_latch),
        .hub_row_addr   (hub_row_addr),
        .hub_rgb1       (hub_rgb1),
        .hub_rgb2       (hub_rgb2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row        (out_row),
        .out_column     (out_column),
        .out_rgb1       (out_rgb1),
        .out_rgb2       (out_rgb2),
        .out_last       (out_last),
        .overrun        (overrun),
        .length_error   (length_error),
        .lines_captured (lines_captured)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] curBeat();
        return {15'd0, out_row, out_column, out_rgb2, out_rgb1, out_last};
    endfunction

    function automatic logic [31:0] allOutputs();
        return {4'd0, out_valid, out_row, out_column, out_rgb1, out_rgb2,
                out_last, overrun, length_error, lines_captured};
    endfunction

    task automatic modelReset();
        modelSr.delete();
        for (int i = 0; i < 64; i++) modelSr.push_back(6'd0);
        expQ.delete();
        modelCount = 0;
        expLines   = 0;
        expOverrun = 1'b0;
        expLenErr  = 1'b0;
    endtask

    task automatic modelShift(input logic [5:0] px);
        modelSr.push_front(px);
        void'(modelSr.pop_back());
        if (modelCount < 65) modelCount++;
    endtask

    task automatic modelLatch(input logic [3:0] row);
        logic [5:0] e;
        if (modelCount != 64) expLenErr = 1'b1;
        if (expQ.size() == 0) begin
            for (int c = 0; c < 64; c++) begin
                e = modelSr[c];
                expQ.push_back({row, 6'(c), e[5:3], e[2:0], (c == 63)});
            end
            expLines = (expLines + 1) % 256;
        end else begin
            expOverrun = 1'b1;
        end
        modelCount = 0;
    endtask

    // One full pixel-clock period: low for two cycles with data set, then high.
    task automatic applyStimulus(input logic [5:0] px);
        @(negedge clk_in);
        hub_rgb1      = px[2:0];
        hub_rgb2      = px[5:3];
        hub_clk_pixel = 1'b0;
        repeat (2) @(negedge clk_in);
        hub_clk_pixel = 1'b1;
        if (cap_enable) modelShift(px);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic pulseLatch(input logic [3:0] row, input bit withPixel,
                              input logic [5:0] px, input bit chkLatency);
        @(negedge clk_in);
        hub_row_addr  = row;
        hub_clk_pixel = 1'b0;
        if (withPixel) begin
            hub_rgb1 = px[2:0];
            hub_rgb2 = px[5:3];
        end
        repeat (2) @(negedge clk_in);
        hub_row_latch = 1'b1;
        hub_clk_pixel = withPixel;
        if (withPixel) modelShift(px);
        modelLatch(row);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_in);
            if (i == 2) hub_row_latch = 1'b0;
            if (chkLatency && i == 4) begin
                #1 checkOutput("latencyEarly", 32'(out_valid), 32'd0);
            end
            if (chkLatency && i == 5) begin
                #1 checkOutput("latencyOnTime", 32'(out_valid), 32'd1);
            end
        end
    endtask

    task automatic holdAt(input int col);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk_in);
            #2;
            if (out_valid && out_column == 6'(col - 1)) begin
                holdReady = 1'b1;
                found     = 1'b1;
            end
        end
        checkOutput("holdReached", 32'(found), 32'd1);
    endtask

    task automatic waitDrain();
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk_in);
            #2;
            done = (expQ.size() == 0) && !out_valid;
        end
        checkOutput("drainDone", 32'(done), 32'd1);
        repeat (5) @(negedge clk_in);
    endtask

    task automatic checkFlags();
        #1;
        checkOutput("overrun", 32'(overrun), 32'(expOverrun));
        checkOutput("lengthError", 32'(length_error), 32'(expLenErr));
        checkOutput("linesCaptured", 32'(lines_captured), 32'(expLines));
    endtask

    task automatic clearFlagsPulse();
        @(negedge clk_in);
        clear_flags = 1'b1;
        @(negedge clk_in);
        clear_flags = 1'b0;
        expOverrun  = 1'b0;
        expLenErr   = 1'b0;
        checkFlags();
    endtask

    task automatic randomLine(input int count);
        for (int k = 0; k < count; k++) applyStimulus(6'($urandom));
    endtask

    // Downstream ready: held low on request, optionally random, else always ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk_in);
            if (holdReady) out_ready = 1'b0;
            else if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Every accepted beat is compared with the next beat the model expects.
    initial begin
        forever begin
            @(negedge clk_in);
            #1;
            if (out_valid && out_ready) begin
                beatsSeen++;
                if (expQ.size() == 0) checkOutput("extraBeat", 32'(beatsSeen), 32'd0);
                else checkOutput("beat", curBeat(), 32'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  saved;
        bit  found;
        modelReset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk_in);
        #1 checkOutput("resetOutputs", allOutputs(), 32'd0);
        @(negedge clk_in);
        reset = 1'b1;

        $display("[TB] line with rgb1 = k mod 8, row 5, stall at column 20");
        for (int k = 0; k < 64; k++) applyStimulus({3'($urandom_range(0, 7)), 3'(k % 8)});
        pulseLatch(4'd5, 1'b0, 6'd0, 1'b1);
        holdAt(20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            #2;
            checkOutput("stallValid", 32'(out_valid), 32'd1);
            checkOutput("stallBeat", curBeat(), 32'(expQ[0]));
        end
        holdReady = 1'b0;
        waitDrain();
        checkFlags();

        $display("[TB] ignored pixels then random line under random backpressure");
        cap_enable = 1'b0;
        randomLine(5);
        repeat (4) @(negedge clk_in);
        cap_enable  = 1'b1;
        randomReady = 1'b1;
        randomLine(64);
        pulseLatch(4'($urandom), 1'b0, 6'd0, 1'b0);
        waitDrain();
        randomReady = 1'b0;
        checkFlags();

        $display("[TB] second latch while column 30 is held");
        randomLine(64);
        pulseLatch(4'($urandom), 1'b0, 6'd0, 1'b0);
        holdAt(30);
        randomLine(64);
        pulseLatch(4'($urandom), 1'b0, 6'd0, 1'b0);
        repeat (10) @(negedge clk_in);
        checkFlags();
        holdReady = 1'b0;
        waitDrain();
        repeat (30) @(negedge clk_in);
        #1 checkOutput("noSecondStream", 32'(out_valid), 32'd0);
        clearFlagsPulse();

        $display("[TB] short line of 63 shifts");
        randomLine(63);
        pulseLatch(4'($urandom), 1'b0, 6'd0, 1'b0);
        waitDrain();
        checkFlags();
        clearFlagsPulse();

        $display("[TB] 64th pixel coincident with latch");
        randomLine(63);
        pulseLatch(4'($urandom), 1'b1, 6'($urandom), 1'b0);
        waitDrain();
        checkFlags();

        $display("[TB] reset in the middle of a drain");
        randomLine(64);
        pulseLatch(4'($urandom), 1'b0, 6'd0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk_in);
            #2;
            found = out_valid && (out_column == 6'd40);
        end
        checkOutput("reachedColumn40", 32'(found), 32'd1);
        reset = 1'b0;
        modelReset();
        #1 checkOutput("resetMidDrain", allOutputs(), 32'd0);
        @(negedge clk_in);
        reset = 1'b1;
        saved = beatsSeen;
        repeat (100) @(negedge clk_in);
        #1;
        checkOutput("noBeatAfterReset", 32'(beatsSeen), 32'(saved));
        checkOutput("idleAfterReset", 32'(out_valid), 32'd0);

        $display("[TB] recovery line after reset");
        randomReady = 1'b1;
        randomLine(64);
        pulseLatch(4'($urandom), 1'b0, 6'd0, 1'b1);
        waitDrain();
        randomReady = 1'b0;
        checkFlags();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Panel-side receiver for the HUB75 stream that matrix_scan produces. It acts as a cycle-accurate stand-in for the LED panel's shift registers, for bench and loopback checking.
- It oversamples pixel clock, row latch, row address and RGB1/RGB2 in the fast clk_in domain.
- It rebuilds each latched line into a 64-column holding buffer and replays that line as a valid/ready pixel stream.
- Overrun and length errors are flagged, and latched lines are counted.

Parameters:
- COLUMNS, 64: pixels per shifted line.
- COL_WIDTH, 6: width of out_column (log2 COLUMNS).
- ROW_WIDTH, 4: width of the HUB75 row address.
- SYNC_STAGES, 2: synchronizer depth on every hub_* input.

Ports:
- clk_in  input  1  capture clock; must be at least 4x the HUB75 pixel clock.
- reset  input  1  asynchronous, active-low reset.
- cap_enable  input  1  high = accept pixel-clock and latch edges.
- clear_flags  input  1  one-cycle pulse; clears overrun and length_error.
- hub_clk_pixel  input  1  HUB75 pixel clock; data is shifted on its rising edge.
- hub_row_latch  input  1  HUB75 latch; line is transferred on its rising edge.
- hub_row_addr  input  ROW_WIDTH  HUB75 A..D row address.
- hub_rgb1  input  3  top-half {B,G,R} serial data.
- hub_rgb2  input  3  bottom-half {B,G,R} serial data.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accepts beat.
- out_row  output  ROW_WIDTH  row address captured at the latch.
- out_column  output  COL_WIDTH  physical column of this beat.
- out_rgb1  output  3  top pixel bits.
- out_rgb2  output  3  bottom pixel bits.
- out_last  output  1  high on the column COLUMNS-1 beat.
- overrun  output  1  sticky: a latch arrived while the holding buffer was still draining.
- length_error  output  1  sticky: the latched line did not contain exactly COLUMNS shifts.
- lines_captured  output  8  count of lines accepted into the holding buffer; wraps 255 -> 0.

Behaviour:
- Reset (reset low, asynchronous): every output is 0, sync chains are 0, the shift count is 0 and the FSM is IDLE. This applies mid-drain too: a partial stream is abandoned with no further beats.
- Input conditioning: all hub_* inputs pass through SYNC_STAGES flops.
  - A rising edge is detected by comparing the last two sync stages, giving a one-cycle pulse.
  - RGB values are taken from the same stage in which the pixel-clock rising edge is detected.
  - Required pixel-clock high/low time is at least 2 clk_in cycles.
- Shift register: COLUMNS x 6 bits.
  - Each pixel-clock edge (with cap_enable high) shifts {rgb2,rgb1} in at entry position 0 and moves the older entries up by one.
  - shift_count increments per edge, saturating at COLUMNS+1.
  - After 64 shifts, the first pixel shifted occupies physical column COLUMNS-1 and the last pixel shifted occupies column 0.
- Latch edge (with cap_enable high):
  - If the FSM is IDLE: copy the shift register and hub_row_addr into the holding buffer, increment lines_captured, and enter DRAIN.
  - If the FSM is in DRAIN: set overrun and discard the new line; the current drain continues unaffected.
  - In both cases: if shift_count != COLUMNS, set length_error (the line is still emitted, with stale entries). shift_count then resets to 0; the shift register contents are kept.
- Pixel edge and latch edge in the same cycle: the shift happens first, and the latched line includes that pixel (count includes it).
- FSM states:
  - IDLE: out_valid = 0.
  - DRAIN: out_valid = 1; out_column starts at 0 and advances on each out_valid & out_ready.
  - On an accepted beat with out_last high, return to IDLE.
  - Beat fields are stable while out_valid is high and out_ready is low.
- Latency: out_valid rises exactly SYNC_STAGES+2 clk_in cycles after the clk_in edge that first samples hub_row_latch high.
- cap_enable low: edges are ignored and shift_count is held; a drain already in progress completes.
- clear_flags and a set event in the same cycle: the set wins.

Decomposition:
- Package hub75_capture_pkg holds:
  - COLUMNS, COL_WIDTH and ROW_WIDTH defaults;
  - the pixel entry width (6);
  - FSM state encoding (IDLE=0, DRAIN=1).
- One sub-module, hub75_edge_sync: a SYNC_STAGES synchronizer plus rising-edge pulse. It is instantiated for hub_clk_pixel and hub_row_latch. Data bits use plain sync chains of matching depth.

Test Plan:
- Shift 64 pixels with values k mod 8 on rgb1 for k=0..63, then latch with row 5 -> 64 beats, out_row=5, column c carries rgb1=(63-c) mod 8, out_last only at column 63, lines_captured=1, both flags 0.
- Hold out_ready low for 10 cycles mid-stream at column 20 -> column 20 beat held stable with out_valid high; the stream resumes at 20 with no beat lost.
- Send a second latch after 64 shifts while column 30 of the current line is still draining -> overrun=1, the current line finishes with correct data, lines_captured stays 1, no second stream.
- Send 63 shifts then a latch -> length_error=1, line still emitted; then pulse clear_flags -> flag returns to 0.
- Make the pixel edge and latch edge coincide on the 64th shift -> no length_error, and column 0 holds that final pixel.
- Assert reset low at column 40 of a drain -> out_valid falls at once, all outputs 0; after release no beats appear until a new latch.
